// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers each digit's hex value and decimal point.
// Each bus state must hold STABLE_CYCLES before it is captured; illegal captures raise a one-cycle err pulse.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned LOWCNT_W = $clog2(DIGITS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       ERR_SEG   = 2'b01;
  localparam logic [1:0]       ERR_MULTI = 2'b10;

  typedef enum logic {SETTLE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
  logic [DIGITS-1:0]     dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_prev_q, dig_prev_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic [DIGITS-1:0]     dp_q, dp_d;
  logic [DIGITS-1:0]     valid_q, valid_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic                  frame_q, frame_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic                  bus_changed;
  logic                  capture;
  logic [LOWCNT_W-1:0]   low_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic [4:0]            dec;

  // Returns {legal, nibble} for an active-high segment pattern g..a
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h67:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Count selected digits; sel_idx is only meaningful when exactly one is low
  always_comb begin
    low_cnt = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!dig_s2_q[i]) begin
        low_cnt = low_cnt + LOWCNT_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    seg_s1_d   = seg_n;
    dig_s1_d   = dig_n;
    seg_s2_d   = seg_s1_q;
    dig_s2_d   = dig_s1_q;
    seg_prev_d = seg_s2_q;
    dig_prev_d = dig_s2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    value_d    = value_q;
    dp_d       = dp_q;
    valid_d    = valid_q;
    err_code_d = err_code_q;
    err_d      = 1'b0;
    frame_d    = &seen_q;
    seen_d     = frame_d ? '0 : seen_q;
    capture    = 1'b0;
    dec        = decode_seg(~seg_s2_q[6:0]);

    bus_changed = (seg_s2_q != seg_prev_q) || (dig_s2_q != dig_prev_q);

    if (bus_changed) begin
      cnt_d   = '0;
      state_d = SETTLE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      // Capture on the cycle the counter reaches its limit
      if (state_q == SETTLE && cnt_q >= CNT_CAP) begin
        capture = 1'b1;
        state_d = HOLD;
      end
    end

    if (capture) begin
      if (low_cnt > LOWCNT_W'(1)) begin
        err_d      = 1'b1;
        err_code_d = ERR_MULTI;
      end else if (low_cnt == LOWCNT_W'(1)) begin
        seen_d[sel_idx] = 1'b1;
        if (dec[4]) begin
          value_d[{sel_idx, 2'b00} +: 4] = dec[3:0];
          dp_d[sel_idx]    = ~seg_s2_q[7];
          valid_d[sel_idx] = 1'b1;
        end else begin
          valid_d[sel_idx] = 1'b0;
          // Blank digit is legal; anything else off-table is an error
          if (seg_s2_q[6:0] != 7'h7F) begin
            err_d      = 1'b1;
            err_code_d = ERR_SEG;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      seg_prev_q <= '1;
      dig_s1_q   <= '1;
      dig_s2_q   <= '1;
      dig_prev_q <= '1;
      state_q    <= SETTLE;
      cnt_q      <= '0;
      value_q    <= '0;
      dp_q       <= '0;
      valid_q    <= '0;
      seen_q     <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      seg_s1_q   <= seg_s1_d;
      seg_s2_q   <= seg_s2_d;
      seg_prev_q <= seg_prev_d;
      dig_s1_q   <= dig_s1_d;
      dig_s2_q   <= dig_s2_d;
      dig_prev_q <= dig_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: a behavioural model queues expected err/frame pulses
// at stimulus time and a negedge monitor pops them as the DUT pulses.
module tb_seg7_scan_decoder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;
  logic [1:0]  err_code;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_n(dig_n),
    .value(value), .dp(dp), .digit_valid(digit_valid),
    .frame_valid(frame_valid), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          frames_seen = 0;
  logic [15:0] exp_value;
  logic [3:0]  exp_dp, exp_valid, exp_seen;
  logic [11:0] last_bus;

  function automatic logic [6:0] pattern_of(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h67; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] enc(input logic [3:0] nib, input logic dp_on);
    return ~{dp_on, pattern_of(nib)};
  endfunction

  // Reference behaviour of one capture of a stable bus state
  function automatic void model_capture(input logic [3:0] d, input logic [7:0] s);
    int   lows;
    int   idx;
    logic found;
    logic [6:0] pat;
    ev_t  ev;
    lows = 0;
    idx  = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) begin lows++; idx = i; end
    if (lows == 0) return;
    if (lows > 1) begin
      ev.is_err = 1'b1; ev.code = 2'b10; exp_q.push_back(ev);
      return;
    end
    pat   = ~s[6:0];
    found = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (pattern_of(4'(n)) == pat) begin
        found = 1'b1;
        exp_value[idx*4 +: 4] = 4'(n);
        exp_dp[idx]    = ~s[7];
        exp_valid[idx] = 1'b1;
      end
    end
    if (!found) begin
      exp_valid[idx] = 1'b0;
      if (pat != 7'h00) begin
        ev.is_err = 1'b1; ev.code = 2'b01; exp_q.push_back(ev);
      end
    end
    exp_seen[idx] = 1'b1;
    if (exp_seen == 4'hF) begin
      ev.is_err = 1'b0; ev.code = 2'b00; exp_q.push_back(ev);
      exp_seen = 4'h0;
    end
  endfunction

  // Drive a bus state for n cycles; called and returns 1 time unit after a rising edge
  task automatic hold_bus(input logic [3:0] d, input logic [7:0] s, input int n);
    dig_n = d;
    seg_n = s;
    if ({d, s} != last_bus && n >= int'(STABLE) + 2) model_capture(d, s);
    last_bus = {d, s};
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    dig_n = 4'hF;
    seg_n = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_value = '0;
    exp_dp    = '0;
    exp_valid = '0;
    exp_seen  = '0;
    last_bus  = {4'hF, 8'hFF};
  endtask

  // Scoreboard side: every err / frame_valid pulse must match the next queued expectation
  always @(negedge clk) begin
    ev_t ev;
    if (frame_valid) frames_seen++;
    if (err || frame_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got err=%0b frame=%0b code=%b, required no pulse", err, frame_valid, err_code);
      end else begin
        ev = exp_q.pop_front();
        if (err !== ev.is_err || frame_valid !== !ev.is_err || (ev.is_err && err_code !== ev.code)) begin
          failures++;
          $display("FAIL pulse_match got err=%0b frame=%0b code=%b, required err=%0b frame=%0b code=%b",
                   err, frame_valid, err_code, ev.is_err, !ev.is_err, ev.code);
        end
      end
    end
  end

  task automatic test_reset();
    rst   = 1'b1;
    dig_n = 4'b1110;
    seg_n = enc(4'h1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (value !== 16'h0)      begin failures++; $display("FAIL reset_value got=%h required=0000", value); end
    checks++; if (digit_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b required=0000", digit_valid); end
    checks++; if (dp !== 4'h0)          begin failures++; $display("FAIL reset_dp got=%b required=0000", dp); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b required=0", frame_valid); end
    checks++; if (err !== 1'b0)         begin failures++; $display("FAIL reset_err got=%b required=0", err); end
    checks++; if (err_code !== 2'b00)   begin failures++; $display("FAIL reset_err_code got=%b required=00", err_code); end
    dig_n     = 4'hF;
    seg_n     = 8'hFF;
    rst       = 1'b0;
    exp_value = '0; exp_dp = '0; exp_valid = '0; exp_seen = '0;
    last_bus  = {4'hF, 8'hFF};
    hold_bus(4'hF, 8'hFF, 12);
  endtask

  task automatic test_single_digit();
    hold_bus(4'b1110, enc(4'h2, 1'b0), 10);
    checks++; if (value[3:0] !== 4'h0)  begin failures++; $display("FAIL early_value got=%h required=0 at cycle 10", value[3:0]); end
    checks++; if (digit_valid !== 4'h0) begin failures++; $display("FAIL early_valid got=%b required=0000 at cycle 10", digit_valid); end
    @(posedge clk); #1;
    checks++; if (value[3:0] !== 4'h2)     begin failures++; $display("FAIL cap_value got=%h required=2", value[3:0]); end
    checks++; if (digit_valid !== 4'b0001) begin failures++; $display("FAIL cap_valid got=%b required=0001", digit_valid); end
    checks++; if (dp[0] !== 1'b0)          begin failures++; $display("FAIL cap_dp got=%b required=0", dp[0]); end
    @(posedge clk); #1;
    checks++; if (value !== exp_value) begin failures++; $display("FAIL hold_value got=%h required=%h", value, exp_value); end
    hold_bus(4'hF, 8'hFF, 12);
  endtask

  task automatic test_scan_frame();
    int f0;
    do_reset();
    f0 = frames_seen;
    hold_bus(4'b0111, enc(4'hB, 1'b0), 10);
    hold_bus(4'b1011, enc(4'hE, 1'b0), 10);
    hold_bus(4'b1101, enc(4'hE, 1'b1), 10);
    hold_bus(4'b1110, enc(4'hF, 1'b0), 10);
    hold_bus(4'hF, 8'hFF, 12);
    checks++; if (value !== 16'hBEEF)   begin failures++; $display("FAIL scan_value got=%h required=BEEF", value); end
    checks++; if (dp !== 4'b0010)       begin failures++; $display("FAIL scan_dp got=%b required=0010", dp); end
    checks++; if (digit_valid !== 4'hF) begin failures++; $display("FAIL scan_valid got=%b required=1111", digit_valid); end
    checks++; if (frames_seen !== f0 + 1) begin failures++; $display("FAIL scan_frames got=%0d required=%0d", frames_seen - f0, 1); end
  endtask

  task automatic test_glitch();
    hold_bus(4'b1110, enc(4'h1, 1'b0), 5);
    checks++; if (value[3:0] !== 4'hF) begin failures++; $display("FAIL glitch_mid got=%h required=F", value[3:0]); end
    hold_bus(4'b1110, enc(4'h3, 1'b0), 12);
    checks++; if (value[3:0] !== 4'h3)   begin failures++; $display("FAIL glitch_value got=%h required=3", value[3:0]); end
    checks++; if (digit_valid[0] !== 1'b1) begin failures++; $display("FAIL glitch_valid got=%b required=1", digit_valid[0]); end
    hold_bus(4'hF, 8'hFF, 12);
  endtask

  task automatic test_illegal();
    hold_bus(4'b1100, enc(4'h0, 1'b0), 12);
    checks++; if (err_code !== 2'b10)  begin failures++; $display("FAIL multi_code got=%b required=10", err_code); end
    checks++; if (value !== exp_value) begin failures++; $display("FAIL multi_value got=%h required=%h", value, exp_value); end
    hold_bus(4'b1110, 8'hFE, 12);
    checks++; if (err_code !== 2'b01)      begin failures++; $display("FAIL seg_code got=%b required=01", err_code); end
    checks++; if (digit_valid[0] !== 1'b0) begin failures++; $display("FAIL seg_valid got=%b required=0", digit_valid[0]); end
    hold_bus(4'hF, 8'hFF, 12);
    checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL code_held got=%b required=01", err_code); end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    do_reset();
    hold_bus(4'b0111, enc(4'h8, 1'b0), 12);
    hold_bus(4'b1011, enc(4'h9, 1'b0), 12);
    do_reset();
    f0 = frames_seen;
    hold_bus(4'b1101, enc(4'h6, 1'b0), 12);
    hold_bus(4'b1110, enc(4'h7, 1'b0), 12);
    hold_bus(4'hF, 8'hFF, 12);
    checks++; if (frames_seen !== f0) begin failures++; $display("FAIL partial_frame got=%0d required=%0d", frames_seen - f0, 0); end
    hold_bus(4'b0111, enc(4'h4, 1'b0), 12);
    hold_bus(4'b1011, enc(4'h5, 1'b0), 12);
    hold_bus(4'hF, 8'hFF, 12);
    checks++; if (frames_seen !== f0 + 1) begin failures++; $display("FAIL full_frame got=%0d required=%0d", frames_seen - f0, 1); end
    checks++; if (value !== 16'h4567)     begin failures++; $display("FAIL refill_value got=%h required=4567", value); end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_scan_frame();
    test_glitch();
    test_illegal();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got=%0d outstanding required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
